// File: rtl/fir_pkg.sv
// Shared definitions for the FIR engine: sequencer state encoding and BRAM word addressing.
// Each BRAM word occupies WORD_BYTES bytes, so word k lives at byte address WORD_BYTES*k.
package fir_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_MAC     = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return 32'(idx) * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate: acc += a*b on en, cleared by clr (clr wins); one cycle latency.
// No flow control; the caller gates en with operand validity.
module fir_mac
  import fir_pkg::*;
#(
  parameter int W = WORD_BYTES * 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] prod;

  // The low W bits of a signed product equal those of the unsigned one.
  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_engine_ctrl.sv
// FIR sequencer: zeroes history, then per sample stores one input and walks all taps through one MAC.
// Input handshake to sm_tvalid is Tape_Num+2 cycles; one result in flight, sm_tready low stalls input.
module fir_engine_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   tap_busy,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int KW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(Tape_Num - 1);
  localparam logic [KW-1:0] N_K    = KW'(Tape_Num);

  state_t                 state_q;
  logic [KW-1:0]          k_q;
  logic [KW-1:0]          wp_q;
  logic [31:0]            cnt_q;
  logic [31:0]            len_q;
  logic                   sm_tvalid_q;
  logic                   sm_tlast_q;
  logic                   ap_done_q;
  logic                   mac_en_q;
  logic                   in_hs;
  logic                   last_sample;
  logic [KW-1:0]          rd_idx;
  logic [pDATA_WIDTH-1:0] acc;
  logic                   unused_tlast;

  // The stream's own framing is ignored; the programmed length ends a run.
  assign unused_tlast = ss_tlast;

  assign in_hs       = (state_q == S_WAIT_IN) && ss_tvalid;
  assign last_sample = (cnt_q == len_q - 32'd1);

  // (wp - k) mod N without a divider; KW-bit wrap makes the borrow-add of N exact.
  assign rd_idx = (wp_q >= k_q) ? (wp_q - k_q) : (wp_q + N_K - k_q);

  always_comb begin
    ss_tready = 1'b0;
    data_WE   = 4'h0;
    data_EN   = 1'b0;
    data_A    = '0;
    data_Di   = '0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    case (state_q)
      S_CLEAR: begin
        data_EN = 1'b1;
        tap_EN  = 1'b1;
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'(word_addr(16'(k_q)));
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          tap_EN  = 1'b1;
          data_WE = 4'hF;
          data_A  = pADDR_WIDTH'(word_addr(16'(wp_q)));
          data_Di = ss_tdata;
        end
      end
      S_MAC: begin
        data_EN = 1'b1;
        tap_EN  = 1'b1;
        tap_A   = pADDR_WIDTH'(word_addr(16'(k_q)));
        data_A  = pADDR_WIDTH'(word_addr(16'(rd_idx)));
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      wp_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sm_tvalid_q <= 1'b0;
      sm_tlast_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      mac_en_q    <= 1'b0;
    end else begin
      ap_done_q <= 1'b0;
      // BRAM read data lags the address by one cycle, so the MAC enable does too.
      mac_en_q  <= (state_q == S_MAC);
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            state_q <= S_CLEAR;
            k_q     <= '0;
            wp_q    <= '0;
            cnt_q   <= '0;
            len_q   <= data_length;
          end
        end
        S_CLEAR: begin
          if (k_q == K_LAST) begin
            k_q <= '0;
            if (len_q == 32'd0) begin
              state_q   <= S_IDLE;
              ap_done_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_IN;
            end
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_WAIT_IN: begin
          if (in_hs) begin
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= S_OUT;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_OUT: begin
          // First OUT cycle absorbs the final product before the result is offered.
          if (!sm_tvalid_q) begin
            sm_tvalid_q <= 1'b1;
            sm_tlast_q  <= last_sample;
          end else if (sm_tready) begin
            sm_tvalid_q <= 1'b0;
            sm_tlast_q  <= 1'b0;
            wp_q        <= (wp_q == K_LAST) ? '0 : wp_q + KW'(1);
            cnt_q       <= cnt_q + 32'd1;
            if (last_sample) begin
              state_q   <= S_IDLE;
              ap_done_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_IN;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fir_mac #(
    .W (pDATA_WIDTH)
  ) u_mac (
    .clk_i  (axis_clk),
    .rst_ni (axis_rst_n),
    .clr_i  (in_hs),
    .en_i   (mac_en_q),
    .a_i    (tap_Do),
    .b_i    (data_Do),
    .acc_o  (acc)
  );

  assign ap_idle   = (state_q == S_IDLE);
  assign tap_busy  = ~ap_idle;
  assign ap_done   = ap_done_q;
  assign sm_tvalid = sm_tvalid_q;
  assign sm_tlast  = sm_tlast_q;
  assign sm_tdata  = acc;

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// Bench for fir_engine_ctrl: BRAM models, golden FIR model feeding a scoreboard, edge scenarios.
module tb_fir_engine_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_idle, ap_done, tap_busy;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tready, sm_tvalid, sm_tlast;
  logic [31:0] sm_tdata;
  logic        tap_EN, data_EN;
  logic [11:0] tap_A, data_A;
  logic [31:0] tap_Do, data_Do, data_Di;
  logic [3:0]  data_WE;

  fir_engine_ctrl dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .tap_busy    (tap_busy),
    .ss_tvalid   (ss_tvalid),
    .ss_tdata    (ss_tdata),
    .ss_tlast    (ss_tlast),
    .ss_tready   (ss_tready),
    .sm_tready   (sm_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do),
    .data_WE     (data_WE),
    .data_EN     (data_EN),
    .data_Di     (data_Di),
    .data_A      (data_A),
    .data_Do     (data_Do)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] taps [0:10];
  logic [31:0] hist [0:10];
  logic [31:0] tap_mem  [0:1023];
  logic [31:0] data_mem [0:1023];
  logic [31:0] first_dat, first_x;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;

  always @(posedge axis_clk) cyc <= cyc + 1;
  always @(negedge axis_clk) if (ap_done) done_cnt <= done_cnt + 1;

  // Synchronous BRAM models with one-cycle read latency.
  logic [31:0] we_mask;
  assign we_mask = {{8{data_WE[3]}}, {8{data_WE[2]}}, {8{data_WE[1]}}, {8{data_WE[0]}}};
  always @(posedge axis_clk) begin
    if (tap_EN) tap_Do <= tap_mem[tap_A[11:2]];
    if (data_EN) begin
      data_Do <= data_mem[data_A[11:2]];
      data_mem[data_A[11:2]] <= (data_mem[data_A[11:2]] & ~we_mask) | (data_Di & we_mask);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_push(input logic [31:0] x, input logic last);
    exp_t   e;
    longint acc;
    for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < 11; k++) acc += longint'($signed(taps[k])) * longint'($signed(hist[k]));
    e.dat  = acc[31:0];
    e.last = last;
    e.cyc  = cyc;
    sb.push_back(e);
  endfunction

  task automatic start_run(input int len);
    for (int k = 0; k < 11; k++) hist[k] = '0;
    @(negedge axis_clk);
    data_length = 32'(len);
    ap_start = 1'b1;
    @(negedge axis_clk);
    ap_start = 1'b0;
    check("busy_running", tap_busy, 1);
  endtask

  task automatic drive(input int len, input int xmode, input bit poke);
    logic [31:0] x;
    int          guard;
    for (int n = 0; n < len; n++) begin
      case (xmode)
        0:       x = (n == 0) ? 32'd1 : 32'd0;
        1:       x = 32'(n + 1);
        default: x = $urandom;
      endcase
      if (xmode == 2) repeat ($urandom_range(0, 2)) @(negedge axis_clk);
      if (n == 0) first_x = x;
      ss_tdata  = x;
      ss_tlast  = 1'($urandom_range(0, 1));
      ss_tvalid = 1'b1;
      guard = 0;
      while (!ss_tready && guard < 5000) begin
        @(negedge axis_clk);
        guard++;
      end
      if (!ss_tready) begin
        check("in_timeout", 0, 1);
        ss_tvalid = 1'b0;
        return;
      end
      model_push(x, n == len - 1);
      @(negedge axis_clk);
      ss_tvalid = 1'b0;
      if (poke && n == 1) begin
        ap_start = 1'b1;
        check("busy_in_mac", tap_busy, 1);
        @(negedge axis_clk);
        ap_start = 1'b0;
      end
    end
  endtask

  task automatic monitor(input int len, input int rmode, input bit lat_chk);
    int          got, guard, hold;
    bit          prev_vld, bad_stable, bad_rdy;
    logic [31:0] held;
    exp_t        e;
    got = 0; guard = 0; hold = 0;
    prev_vld = 1'b0; bad_stable = 1'b0; bad_rdy = 1'b0; held = '0;
    while (got < len && guard < 5000) begin
      @(negedge axis_clk);
      guard++;
      if (lat_chk && sm_tvalid && !prev_vld && sb.size() > 0) check("latency", cyc - sb[0].cyc, 13);
      prev_vld = sm_tvalid;
      case (rmode)
        1: sm_tready = ($urandom_range(0, 3) != 0);
        2: begin
          if (sm_tvalid && got == 3 && hold < 20) begin
            sm_tready = 1'b0;
            if (hold == 0) held = sm_tdata;
            else if (sm_tdata !== held) bad_stable = 1'b1;
            if (ss_tready) bad_rdy = 1'b1;
            hold++;
            if (hold == 20) begin
              check("bp_tdata_stable", bad_stable, 0);
              check("bp_ss_tready_low", bad_rdy, 0);
            end
          end else begin
            sm_tready = 1'b1;
          end
        end
        default: sm_tready = 1'b1;
      endcase
      if (sm_tvalid && sm_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sm_tdata", sm_tdata, e.dat);
          check("sm_tlast", sm_tlast, e.last);
        end
        if (got == 0) first_dat = sm_tdata;
        got++;
      end
    end
    if (got < len) check("out_timeout", got, len);
    sm_tready = 1'b1;
  endtask

  task automatic run(input int len, input int xmode, input int rmode, input bit lat_chk, input bit poke);
    int d0;
    d0 = done_cnt;
    start_run(len);
    fork
      drive(len, xmode, poke);
      monitor(len, rmode, lat_chk);
    join
    @(negedge axis_clk);
    check("done_pulse", ap_done, 1);
    check("idle_after", ap_idle, 1);
    @(negedge axis_clk);
    check("done_count", done_cnt - d0, 1);
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int          n, wr, d0, guard;
    bit          act;
    longint      p;
    axis_rst_n = 1'b0; ap_start = 1'b0; data_length = '0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      data_mem[i] = $urandom;
      tap_mem[i]  = '0;
    end
    repeat (3) @(negedge axis_clk);
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_busy", tap_busy, 0);
    check("rst_ss_tready", ss_tready, 0);
    check("rst_sm_tvalid", sm_tvalid, 0);
    check("rst_sm_tdata", sm_tdata, 0);
    check("rst_data_en", {data_EN, tap_EN, data_WE}, 0);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    check("idle_not_busy", tap_busy, 0);

    // Impulse through taps 1..11 with latency measured on every sample.
    for (int k = 0; k < 11; k++) begin
      taps[k] = 32'(k + 1);
      tap_mem[k] = taps[k];
    end
    run(12, 0, 0, 1'b1, 1'b0);

    // 20-cycle back-pressure hold on the fourth result.
    run(8, 2, 2, 1'b0, 1'b0);

    // Signed random taps, 30-sample ramp with random output readiness (pointer wraps twice).
    for (int k = 0; k < 11; k++) begin
      taps[k] = $urandom;
      tap_mem[k] = taps[k];
    end
    run(30, 1, 1, 1'b0, 1'b0);

    // Restart: CLEAR must wipe the ramp history.
    run(5, 2, 0, 1'b0, 1'b0);
    p = longint'($signed(taps[0])) * longint'($signed(first_x));
    check("restart_first", first_dat, p[31:0]);

    // Zero-length run.
    d0 = done_cnt;
    @(negedge axis_clk);
    data_length = '0;
    ap_start = 1'b1;
    @(negedge axis_clk);
    ap_start = 1'b0;
    n = 1;
    wr = (data_EN && data_WE == 4'hF) ? 1 : 0;
    act = ss_tready || sm_tvalid;
    while (!ap_done && n < 100) begin
      @(negedge axis_clk);
      n++;
      if (data_EN && data_WE == 4'hF) wr++;
      if (ss_tready || sm_tvalid) act = 1'b1;
    end
    check("len0_done_cycle", n, 12);
    check("len0_clear_writes", wr, 11);
    check("len0_no_stream", act, 0);
    @(negedge axis_clk);
    check("len0_done_count", done_cnt - d0, 1);

    // ap_start pulsed during MAC is ignored.
    run(6, 2, 1, 1'b0, 1'b1);

    // Reset in the middle of MAC.
    start_run(5);
    ss_tdata = 32'h1234;
    ss_tvalid = 1'b1;
    guard = 0;
    while (!ss_tready && guard < 100) begin
      @(negedge axis_clk);
      guard++;
    end
    check("rst_mid_accept", ss_tready, 1);
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    repeat (3) @(negedge axis_clk);
    d0 = done_cnt;
    axis_rst_n = 1'b0;
    #1;
    check("midrst_idle", ap_idle, 1);
    check("midrst_busy", tap_busy, 0);
    check("midrst_done", ap_done, 0);
    check("midrst_bram_en", {data_EN, tap_EN}, 0);
    check("midrst_streams", {ss_tready, sm_tvalid}, 0);
    check("midrst_acc", sm_tdata, 0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    act = 1'b0;
    repeat (20) begin
      @(negedge axis_clk);
      if (sm_tvalid || !ap_idle) act = 1'b1;
    end
    check("midrst_quiet", act, 0);
    check("midrst_no_done", done_cnt - d0, 0);

    // Recovery after reset.
    run(3, 2, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
